// File: rtl/mem_ctrl.sv
// mem_ctrl: serial byte-wide memory controller shared by instruction fetch
// (IF) and load/store (LS) ports.
//
// Every request moves 1, 2 or 4 bytes, one per cycle, over an 8-bit RAM/IO
// bus, at ascending addresses. Addresses whose bits
// [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] are 2'b11 select the I/O region. Stores to
// I/O wait per byte while the UART transmit buffer is full.
//
// Handshake: a requester raises *_valid with its fields and keeps it high
// until the matching one-cycle *_done pulse. A request is taken on the rising
// edge where the FSM is IDLE and sees it, with LS winning over IF. The fields
// are copied at that edge, so later changes to the inputs are ignored.
// *_data stays stable until the next *_done on the same port.
//
// Optional build macro:
//   MEM_CTRL_FETCH_ABORT_EN - if_clear aborts an in-flight fetch (IF_RD goes
//                             to IDLE, no if_done) and masks if_valid in IDLE.
//                             When undefined, if_clear is ignored.
//
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (0 = freeze everything)
//   if_valid/if_addr/if_clear -> if_done/if_data   : fetch port
//   ls_valid/ls_wr/ls_addr/ls_size/ls_wdata
//                             -> ls_done/ls_rdata  : load/store port
//   mem_din (byte valid one cycle after its address), mem_dout, mem_a, mem_wr
//   io_buffer_full : UART TX buffer full, stalls I/O store bytes
//   dbg_state      : current FSM state encoding, for observation only
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  input  logic        if_clear,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IF_RD = 3'd1,
    LS_RD = 3'd2,
    LS_WR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;      // index of the byte currently on the bus
  logic [2:0]  nbytes;           // transfer length latched at accept
  logic [31:0] base;
  logic [31:0] wdata_q;
  logic        is_ls;            // owner of the transfer in flight
  logic [31:0] rd_buf;           // bytes captured so far
  logic [31:0] rd_word;          // rd_buf with mem_din merged in
  logic [31:0] cur_addr;
  logic [1:0]  cap_idx;
  logic        cur_io;
  logic        is_rd;
  logic        wr_stall;
  logic        accept_ls;
  logic        accept_if;
  logic        abort_fetch;
  logic        drop_if;

`ifdef MEM_CTRL_FETCH_ABORT_EN
  assign abort_fetch = if_clear && (state == IF_RD);
  assign drop_if     = if_clear;
`else
  logic unused_if_clear;
  assign unused_if_clear = if_clear;
  assign abort_fetch     = 1'b0;
  assign drop_if         = 1'b0;
`endif

  assign cur_addr = base + {29'd0, cnt};
  assign cur_io   = (cur_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign is_rd    = (state == IF_RD) || (state == LS_RD);
  assign wr_stall = cur_io && io_buffer_full;

  // The byte on mem_din belongs to the address driven one cycle earlier,
  // i.e. index cnt-1. At cnt==0 nothing valid is captured.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    rd_word = rd_buf;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  assign if_done   = (state == DONE) && !is_ls;
  assign ls_done   = (state == DONE) &&  is_ls;
  assign dbg_state = state;

  // Next state and bus outputs. Reads run cnt from 0 to nbytes: the extra
  // step at cnt==nbytes captures the last byte with no address on the bus,
  // so each I/O address is presented exactly once.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept_ls = 1'b0;
    accept_if = 1'b0;
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (ls_valid) begin
          accept_ls = 1'b1;
          state_nx  = ls_wr ? LS_WR : LS_RD;
        end else if (if_valid && !drop_if) begin
          accept_if = 1'b1;
          state_nx  = IF_RD;
        end
      end
      IF_RD, LS_RD: begin
        if (cnt != nbytes) mem_a = cur_addr;
        if (abort_fetch) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == nbytes) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      LS_WR: begin
        // While an I/O byte waits for buffer space the bus stays all-zero.
        if (!wr_stall) begin
          mem_a    = cur_addr;
          mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
          mem_wr   = rdy_in;
          if (cnt == nbytes - 3'd1) state_nx = DONE;
          else                      cnt_nx   = cnt + 3'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      nbytes   <= '0;
      base     <= '0;
      wdata_q  <= '0;
      is_ls    <= 1'b0;
      rd_buf   <= '0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy_in) begin
      if (accept_ls) begin
        base    <= ls_addr;
        wdata_q <= ls_wdata;
        is_ls   <= 1'b1;
        rd_buf  <= '0;
        case (ls_size)
          2'd0:    nbytes <= 3'd1;
          2'd1:    nbytes <= 3'd2;
          default: nbytes <= 3'd4;
        endcase
      end else if (accept_if) begin
        base   <= if_addr;
        is_ls  <= 1'b0;
        rd_buf <= '0;
        nbytes <= 3'd4;
      end
      if (is_rd && (cnt != 3'd0)) rd_buf <= rd_word;
      // Result registers only move when a read completes, which keeps each
      // port's data stable between its own done pulses.
      if (is_rd && (state_nx == DONE)) begin
        if (is_ls) ls_rdata <= rd_word;
        else       if_data  <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
module tb_mem_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_clear;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_valid;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_valid(if_valid), .if_addr(if_addr), .if_clear(if_clear),
    .if_done(if_done), .if_data(if_data),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // ---------------- memory world + reference model ----------------
  logic [7:0]  ram     [0:262143];   // what the DUT talks to
  logic [7:0]  ref_mem [0:262143];   // what the model believes memory holds
  int          cyc = 0;
  int          io_rd_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [39:0] exp_q[$];             // expected {addr, byte} write stream

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    if (rdy_in && !mem_wr && (mem_a[17:16] == 2'b11)) io_rd_cnt <= io_rd_cnt + 1;
  end

  // Write scoreboard: every mem_wr cycle must match the next expected byte.
  always @(negedge clk) begin
    if (mem_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%02h, want no write", mem_a, mem_dout);
      end else begin
        logic [39:0] w;
        w = exp_q.pop_front();
        if ({mem_a, mem_dout} === w) n_pass++;
        else $display("FAIL write_byte: got addr 0x%08h data 0x%02h, want addr 0x%08h data 0x%02h",
                      mem_a, mem_dout, w[39:8], w[7:0]);
      end
    end
  end

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] w;
    logic [31:0] ai;
    w = '0;
    for (int i = 0; i < n; i++) begin
      ai = addr + 32'(i);
      w[8*i +: 8] = ref_mem[ai[17:0]];
    end
    return w;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] ai;
    for (int i = 0; i < nbytes_of(size); i++) begin
      ai = addr + 32'(i);
      exp_q.push_back({ai, wdata[8*i +: 8]});
      ref_mem[ai[17:0]] = wdata[8*i +: 8];
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    ram[addr[17:0]]     = b;
    ref_mem[addr[17:0]] = b;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a done pulse; returns its cycle number, or -1 if it
  // never came, so the caller's latency check fails. Then drops the port's
  // valid and checks the idle bus.
  task automatic wait_done(input bit on_ls, input bit scramble,
                           output int done_cyc, output logic [31:0] data);
    done_cyc = -1;
    data     = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (scramble && k == 1) begin
        if_addr  = $urandom;
        ls_addr  = $urandom;
        ls_wdata = $urandom;
        ls_size  = 2'($urandom_range(0, 3));
      end
      if (on_ls ? ls_done : if_done) begin
        done_cyc = cyc;
        data     = on_ls ? ls_rdata : if_data;
        break;
      end
    end
    step();
    if (on_ls) ls_valid = 1'b0;
    else       if_valid = 1'b0;
    @(negedge clk);
    check("idle_bus_zero", mem_a | {24'd0, mem_dout} | {31'd0, mem_wr}, 32'd0);
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, output int lat, output logic [31:0] data);
    int a;
    int dc;
    step();
    if (kind == 0) begin
      if_valid = 1'b1;
      if_addr  = addr;
    end else begin
      ls_valid = 1'b1;
      ls_wr    = (kind == 2);
      ls_addr  = addr;
      ls_size  = size;
      ls_wdata = wdata;
    end
    a = cyc;
    wait_done(kind != 0, 1'b1, dc, data);
    lat = dc - a;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat, a, dc, n, kind, io0;
    logic [31:0] d, addr, wd, expd, last_if, last_ls;
    logic [1:0]  size;

    rst_in = 1'b0; rdy_in = 1'b1; if_valid = 1'b0; if_addr = '0; if_clear = 1'b0;
    ls_valid = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;

    for (int i = 0; i < 262144; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    poke(32'h302, 8'hAA); poke(32'h303, 8'hBB);
    poke(32'h3FFFE, 8'h11); poke(32'h3FFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);
    poke(32'h30010, 8'h01); poke(32'h30011, 8'h02); poke(32'h30012, 8'h03); poke(32'h30013, 8'h04);

    vecs[0]  = '{0, 32'h0000_0100, 2'd2, 32'h0,         32'h0000_0513, 6};
    vecs[1]  = '{1, 32'h0000_0200, 2'd2, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[2]  = '{1, 32'h0000_0201, 2'd0, 32'h0,         32'h0000_00BE, 3};
    vecs[3]  = '{1, 32'h0000_0202, 2'd1, 32'h0,         32'h0000_DEAD, 4};
    vecs[4]  = '{1, 32'h0000_0200, 2'd3, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[5]  = '{2, 32'h0000_0300, 2'd1, 32'h1234_5678, 32'h0,         3};
    vecs[6]  = '{1, 32'h0000_0300, 2'd2, 32'h0,         32'hBBAA_5678, 6};
    vecs[7]  = '{2, 32'h0000_0304, 2'd0, 32'hFFFF_FF99, 32'h0,         2};
    vecs[8]  = '{1, 32'h0000_0304, 2'd0, 32'h0,         32'h0000_0099, 3};
    vecs[9]  = '{1, 32'hFFFF_FFFE, 2'd2, 32'h0,         32'h4433_2211, 6};
    vecs[10] = '{2, 32'hFFFF_FFFF, 2'd1, 32'h0000_CAFE, 32'h0,         3};
    vecs[11] = '{1, 32'hFFFF_FFFF, 2'd1, 32'h0,         32'h0000_CAFE, 4};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst_in = 1'b1;

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].kind == 2) model_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
      do_txn(vecs[i].kind, vecs[i].addr, vecs[i].size, vecs[i].wdata, lat, d);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].kind != 2) check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
    end

    // Collision: load wins, fetch follows after the IDLE cycle
    step();
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h200; ls_size = 2'd2;
    if_valid = 1'b1; if_addr = 32'h100;
    a = cyc;
    wait_done(1'b1, 1'b0, dc, d);
    check("coll_ls_lat", 32'(dc - a), 32'd6);
    check("coll_ls_data", d, 32'hDEAD_BEEF);
    wait_done(1'b0, 1'b0, dc, d);
    check("coll_if_lat", 32'(dc - a), 32'd13);
    check("coll_if_data", d, 32'h0000_0513);

    // I/O store held off by a full UART buffer for 5 cycles
    model_store(32'h30000, 2'd0, 32'h41);
    step();
    io_buffer_full = 1'b1;
    ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_size = 2'd0; ls_wdata = 32'h41;
    a = cyc;
    for (int k = 1; k <= 5; k++) begin
      step();
      @(negedge clk);
      check("io_wait_bus", mem_a | {24'd0, mem_dout} | {31'd0, mem_wr}, 32'd0);
    end
    step();
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_wr_strobe", {31'd0, mem_wr}, 32'd1);
    wait_done(1'b1, 1'b0, dc, d);
    check("io_st_lat", 32'(dc - a), 32'd7);

    // Pause in the middle of a half store
    model_store(32'h10, 2'd1, 32'hBEEF);
    step();
    ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h10; ls_size = 2'd1; ls_wdata = 32'hBEEF;
    a = cyc;
    step();
    step();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pause_no_wr", {31'd0, mem_wr}, 32'd0);
      step();
    end
    rdy_in = 1'b1;
    wait_done(1'b1, 1'b0, dc, d);
    check("pause_lat", 32'(dc - a), 32'd6);

    // I/O load: each I/O address read exactly once
    io0 = io_rd_cnt;
    do_txn(1, 32'h30010, 2'd2, 32'h0, lat, d);
    check("io_ld_data", d, 32'h0403_0201);
    check("io_ld_reads", 32'(io_rd_cnt - io0), 32'd4);

    // Reset in the middle of a word load
    step();
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h200; ls_size = 2'd2;
    step(); step(); step();
    @(negedge clk);
    rst_in = 1'b0;
    #1;
    check("mid_rst_bus", mem_a | {24'd0, mem_dout} | {31'd0, mem_wr}, 32'd0);
    check("mid_rst_ls_rdata", ls_rdata, 32'd0);
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    ls_valid = 1'b0;
    step(); step();
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_done", {30'd0, if_done, ls_done}, 32'd0);
      step();
    end
    do_txn(1, 32'h200, 2'd2, 32'h0, lat, d);
    check("post_rst_lat", 32'(lat), 32'd6);
    check("post_rst_data", d, 32'hDEAD_BEEF);

    // Fetch abort
`ifdef MEM_CTRL_FETCH_ABORT_EN
    step();
    if_valid = 1'b1; if_addr = 32'h100;
    step(); step(); step();
    if_clear = 1'b1; if_valid = 1'b0;
    step();
    if_clear = 1'b0;
    @(negedge clk);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    step();
    if_valid = 1'b1; if_clear = 1'b1;
    step();
    if_valid = 1'b0; if_clear = 1'b0;
    @(negedge clk);
    check("clear_drop_state", {29'd0, dbg_state}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, if_done}, 32'd0);
    end
    last_if = 32'h0;
`else
    step();
    if_valid = 1'b1; if_addr = 32'h100;
    a = cyc;
    step(); step(); step();
    if_clear = 1'b1;
    step();
    if_clear = 1'b0;
    wait_done(1'b0, 1'b0, dc, d);
    check("noabort_lat", 32'(dc - a), 32'd6);
    check("noabort_data", d, 32'h0000_0513);
    last_if = 32'h0000_0513;
`endif
    last_ls = 32'hDEAD_BEEF;

    // Randomized traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(32'h1000, 32'h2FF00));
      wd   = $urandom;
      if (kind == 0) addr[1:0] = 2'b00;
      n = (kind == 0) ? 4 : nbytes_of(size);
      repeat ($urandom_range(0, 2)) step();
      expd = '0;
      if (kind == 2) model_store(addr, size, wd);
      else           expd = model_load(addr, n);
      do_txn(kind, addr, size, wd, lat, d);
      check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(n + ((kind == 2) ? 1 : 2)));
      if (kind == 0) begin
        check($sformatf("rnd%0d_if_data", t), d, expd);
        last_if = expd;
        check($sformatf("rnd%0d_ls_hold", t), ls_rdata, last_ls);
      end else begin
        if (kind == 1) begin
          check($sformatf("rnd%0d_ls_data", t), d, expd);
          last_ls = expd;
        end
        check($sformatf("rnd%0d_if_hold", t), if_data, last_if);
      end
    end

    repeat (3) step();
    check("writes_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want $finish before 2 ms");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: RAM_ADDR_WIDTH, 17, IO region select; address is I/O when addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.
REQ-002 SHALL have ports:
- clk_in  input  1  sole clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  low = pause; all state frozen.
- if_valid  input  1  instruction fetch request, held until if_done.
- if_addr  input  32  fetch address (word aligned).
- if_clear  input  1  abort current fetch (see Configuration).
- if_done  output  1  one-cycle pulse; if_data valid.
- if_data  output  32  fetched word, little-endian.
- ls_valid  input  1  load/store request, held until ls_done.
- ls_wr  input  1  1 = store, 0 = load.
- ls_addr  input  32  data address.
- ls_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- ls_wdata  input  32  store data, low bytes first.
- ls_done  output  1  one-cycle pulse; ls_rdata valid.
- ls_rdata  output  32  load data, zero-extended.
- mem_din  input  8  RAM/IO read byte, valid one cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  32  byte address.
- mem_wr  output  1  1 = write.
- io_buffer_full  input  1  UART transmit buffer full.

Function
REQ-003 SHALL implement states IDLE, IF_RD, LS_RD, LS_WR, DONE.
REQ-004 SHALL arbitrate in IDLE as follows:
- ls_valid has priority over if_valid.
- A request is accepted on the edge where IDLE sees it.
- No new request is accepted in the same cycle as a done pulse.
REQ-005 SHALL transfer N bytes (N = 4 for fetch, 1/2/4 for ls_size) serially, at addresses base+0 .. base+N-1, in ascending order.
REQ-006 Reads SHALL behave as follows:
- Byte i address is driven in cycle A+1+i, where A is the accept cycle.
- The byte is captured from mem_din in cycle A+2+i into bits [8i+7:8i].
- done pulses in cycle A+N+2 (fetch: A+6).
REQ-007 Writes SHALL behave as follows:
- Byte i is driven on mem_a/mem_dout with mem_wr=1 for exactly one cycle.
- Bytes are driven consecutively.
- ls_done pulses in the cycle after the last byte.
REQ-008 Before each I/O write byte, SHALL hold in LS_WR with mem_wr=0 while io_buffer_full=1, and drive the byte in the first cycle io_buffer_full=0.
REQ-009 SHALL read each I/O address exactly once per request; no speculative or repeated reads.
REQ-010 When idle or waiting, SHALL drive mem_wr=0, mem_a=0 and mem_dout=0.
REQ-011 While rdy_in=0, SHALL hold state, counters and outputs, and force mem_wr=0; a write interrupted by rdy_in SHALL re-drive the same byte after rdy_in returns.
REQ-012 SHALL latch request fields at accept; later changes to if_addr/ls_* during the transfer SHALL have no effect.
REQ-013 SHALL keep if_data/ls_rdata stable from the done pulse until the next done pulse on the same port.
REQ-014 Address arithmetic SHALL be 32-bit, wrapping modulo 2^32.

Reset
REQ-015 When rst_in=0, SHALL asynchronously set the following, regardless of any transfer in progress:
- state = IDLE;
- mem_wr, mem_a, mem_dout, if_done, ls_done = 0;
- if_data, ls_rdata = 0;
- byte counter = 0.
REQ-016 After rst_in rises, SHALL accept its first request on the first edge with rdy_in=1.

Configuration
REQ-017 Macro MEM_CTRL_FETCH_ABORT_EN controls fetch abort:
- Defined: if_clear=1 while in IF_RD returns the block to IDLE on the next edge, with no if_done for the aborted fetch; if_clear in IDLE drops a same-cycle if_valid.
- Undefined: if_clear is ignored; every accepted fetch completes with if_done.
- if_clear never affects LS transfers.

Verification
REQ-018 Fetch: if_valid, if_addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> if_done in cycle A+6, if_data=0x00000513; mem_wr=0 throughout.
REQ-019 Collision: if_valid and ls_valid (load, size=2, addr=0x200, RAM=EF BE AD DE) rise in the same cycle -> ls_done with ls_rdata=0xDEADBEEF first, then fetch starts; if_done 6 cycles later.
REQ-020 I/O store: ls_wr=1, size=0, addr=0x30000, wdata=0x41, io_buffer_full=1 for 5 cycles -> mem_wr=0 for those 5 cycles, then a single mem_wr=1 cycle with mem_dout=0x41, then ls_done.
REQ-021 Pause: half store 0xBEEF to 0x10, rdy_in=0 after byte 0 for 3 cycles -> exactly one write cycle each: 0x10<-EF, 0x11<-BE; no mem_wr during the pause.
REQ-022 Reset mid-load: rst_in=0 during byte 2 of a word load -> outputs 0 immediately; no ls_done; the next request completes normally.
REQ-023 Abort (macro defined): if_clear in cycle A+3 -> no if_done, IDLE on the next edge; macro undefined -> if_done at A+6.
